ttl_74148_irq: RTL and testbench
================================

TTL_74148_IRQ -- requirements
Module: ttl_74148_irq

Interface
REQ-001 SHALL have parameter WIDTH_IN, default 8, the number of request lines.
REQ-002 SHALL have parameter WIDTH_OUT, default $clog2(WIDTH_IN), the code width.
REQ-003 SHALL have parameters DELAY_RISE and DELAY_FALL, default 0, the rise and fall delays applied to every output.
REQ-004 SHALL have the following ports (clock and reset first):
  Clk          input   1          rising-edge clock (the block's one clock)
  Clear_bar    input   1          reset, asynchronous, active-low
  Enable_bar   input   1          active-low enable
  D_bar        input   WIDTH_IN   active-low request lines; bit 7 has the highest priority
  Ack          input   1          active-high acknowledge of the current grant
  A_bar        output  WIDTH_OUT  inverted binary code of the granted line
  GS_bar       output  1          active-low group select; low means a grant is valid
  EO_bar       output  1          active-low enable-out; low means enabled, idle and nothing pending

Function
REQ-005 SHALL hold a pending register P[WIDTH_IN-1:0]; at each rising Clk, P[i] <= 1 when D_bar[i]==0, whatever the Enable_bar level.
REQ-006 SHALL leave P[i] set until it is cleared by an acknowledge; P SHALL latch levels, not edges.
REQ-007 SHALL implement a two-state FSM, IDLE and GRANT, plus a code register Cur[WIDTH_OUT-1:0].
REQ-008 In IDLE with Enable_bar==0 and P!=0, the FSM SHALL, at the edge, load Cur with the highest set index of P and move to GRANT.
REQ-009 Request latency SHALL be as follows: D_bar[i] low sampled at edge k sets P at edge k, and the grant becomes visible after edge k+1.
REQ-010 In GRANT, Cur SHALL stay stable; a higher-priority request arriving later SHALL NOT pre-empt the current grant.
REQ-011 In GRANT with Ack==1 at an edge, the FSM SHALL clear P[Cur] and return to IDLE; the next grant, if any is pending, SHALL appear one edge later.
REQ-012 When a set and a clear hit the same bit at the same edge (D_bar[Cur]==0 and Ack==1), the set SHALL win and the bit SHALL stay pending.
REQ-013 Ack in IDLE SHALL be ignored.
REQ-014 Enable_bar==1 SHALL force A_bar to all 1s, GS_bar to 1 and EO_bar to 1 combinationally. An edge seen while Enable_bar==1 SHALL return the FSM to IDLE without clearing P.
REQ-015 Output decode SHALL be:
  - GS_bar = 0 only in GRANT with Enable_bar==0.
  - A_bar = ~Cur when GS_bar==0, otherwise all 1s.
  - EO_bar = 0 only when Enable_bar==0, the FSM is IDLE and P==0.
REQ-016 Every output SHALL be driven through a continuous assignment carrying #(DELAY_RISE, DELAY_FALL).

Reset
REQ-017 Clear_bar==0 SHALL asynchronously set P=0, Cur=0 and the FSM to IDLE, whatever the Clk state, including mid-GRANT.
REQ-018 Output values during and after reset SHALL be A_bar = all 1s, GS_bar = 1 and EO_bar = Enable_bar.
REQ-019 The first edge after Clear_bar rises SHALL sample requests normally.

Verification (WIDTH_IN=8, DELAY_RISE=5, DELAY_FALL=3, checks made 10 units after each edge)
REQ-020 Hold Clear_bar=0 with D_bar=8'b00000000. Expect A_bar=3'b111, GS_bar=1, EO_bar=0. Release Clear_bar. Expect GS_bar=0 and A_bar=3'b000 after the second edge.
REQ-021 Pulse D_bar=8'b11110101 for one cycle (lines 3 and 1 requested).
  - Expect A_bar=3'b100 (code 3).
  - After Ack for one cycle, expect GS_bar=1 for one cycle, then A_bar=3'b110 (code 1).
  - After a second Ack, expect GS_bar=1 and EO_bar=0.
REQ-022 Make D_bar[6] low while code 1 is granted. Expect A_bar to stay 3'b110 until Ack, then A_bar=3'b001 (code 6) after one idle edge.
REQ-023 Raise Enable_bar=1 during a grant of code 5. Expect all outputs 1 immediately, with P kept. Lower Enable_bar. Expect A_bar=3'b010 (code 5) after the next edge.
REQ-024 Assert Ack while D_bar[2] is still low during a grant of code 2. Expect GS_bar=1 for one edge, then A_bar=3'b101 (code 2) again.
REQ-025 Pulse Clear_bar low between edges while a request is pending and a grant is active. Expect the outputs to go inactive without waiting for Clk. After release with D_bar all 1s, expect EO_bar=0 and no grant.

Source files
------------

// File: rtl/ttl_74148_irq.sv
// ---------------------------------------------------------------------------
// ttl_74148_irq
//
// Clocked, latching 8-to-3 style priority interrupt encoder modelled on the
// 74148 pin-out. Requests are captured into a pending register; the highest
// pending line is granted and held until it is acknowledged.
//
// Handshake: a grant is offered while GS_bar is low, and it is consumed at
// the rising Clk edge on which Ack is high. Ack outside a grant has no
// effect. A request that is still asserted when its own grant is acked stays
// pending, so the line is granted again.
//
// Ports
//   Clk         rising-edge clock
//   Clear_bar   asynchronous active-low reset
//   Enable_bar  active-low enable; high forces all outputs inactive
//   D_bar       active-low request lines, highest index has highest priority
//   Ack         active-high acknowledge of the current grant
//   A_bar       inverted binary code of the granted line (all 1s if none)
//   GS_bar      active-low group select, low while a grant is valid
//   EO_bar      active-low enable-out, low when enabled, idle, none pending
// ---------------------------------------------------------------------------
module ttl_74148_irq #(
    parameter int WIDTH_IN   = 8,
    parameter int WIDTH_OUT  = $clog2(WIDTH_IN),
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic                 Clk,
    input  logic                 Clear_bar,
    input  logic                 Enable_bar,
    input  logic [WIDTH_IN-1:0]  D_bar,
    input  logic                 Ack,
    output logic [WIDTH_OUT-1:0] A_bar,
    output logic                 GS_bar,
    output logic                 EO_bar
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [WIDTH_IN-1:0]  pend;
    logic [WIDTH_IN-1:0]  pend_next;
    logic [WIDTH_IN-1:0]  ack_mask;
    logic [WIDTH_OUT-1:0] cur;
    logic [WIDTH_OUT-1:0] cur_next;
    logic [WIDTH_OUT-1:0] top_idx;
    logic                 pend_any;

    logic [WIDTH_OUT-1:0] a_bar_int;
    logic                 gs_bar_int;
    logic                 eo_bar_int;

    // Highest set index of the pending register; later iterations overwrite
    // earlier ones, so the top-most set bit wins.
    always_comb begin
        top_idx = '0;
        for (int i = 0; i < WIDTH_IN; i++) begin
            if (pend[i]) begin
                top_idx = WIDTH_OUT'(i);
            end
        end
    end

    assign pend_any = |pend;

    // Pending update: an acknowledged grant clears its bit first, then any
    // request sampled low at this edge sets bits, so a simultaneous set and
    // clear on the same line leaves it pending. Requests are captured even
    // while disabled, and a disabled edge never acknowledges.
    always_comb begin
        ack_mask = '0;
        if ((state == GRANT) && !Enable_bar && Ack) begin
            ack_mask[cur] = 1'b1;
        end
        pend_next = (pend & ~ack_mask) | ~D_bar;
    end

    // Next-state logic. The grant decision uses the registered pending bits,
    // which gives one edge of latency from capture to grant.
    always_comb begin
        state_next = state;
        cur_next   = cur;
        if (Enable_bar) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (pend_any) begin
                        state_next = GRANT;
                        cur_next   = top_idx;
                    end
                end
                GRANT: begin
                    // No pre-emption: only Ack releases the current grant.
                    if (Ack) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            state <= IDLE;
            pend  <= '0;
            cur   <= '0;
        end else begin
            state <= state_next;
            pend  <= pend_next;
            cur   <= cur_next;
        end
    end

    // Output decode; Enable_bar gates every output combinationally.
    always_comb begin
        gs_bar_int = ~((state == GRANT) && !Enable_bar);
        a_bar_int  = gs_bar_int ? '1 : ~cur;
        eo_bar_int = ~(!Enable_bar && (state == IDLE) && !pend_any);
    end

    assign #(DELAY_RISE, DELAY_FALL) A_bar  = a_bar_int;
    assign #(DELAY_RISE, DELAY_FALL) GS_bar = gs_bar_int;
    assign #(DELAY_RISE, DELAY_FALL) EO_bar = eo_bar_int;

endmodule

// File: tb/tb_ttl_74148_irq.sv
// ---------------------------------------------------------------------------
// tb_ttl_74148_irq
//
// Directed scenarios followed by a randomized run. Expected outputs come from
// a behavioural model holding the pending lines as a bit array and the grant
// as a line number (-1 when nothing is granted).
// ---------------------------------------------------------------------------
module tb_ttl_74148_irq;

    logic       Clk;
    logic       Clear_bar;
    logic       Enable_bar;
    logic [7:0] D_bar;
    logic       Ack;
    logic [2:0] A_bar;
    logic       GS_bar;
    logic       EO_bar;

    int n_cmp;
    int n_fail;

    // Behavioural model state.
    bit pend[8];
    int grant;

    ttl_74148_irq #(
        .WIDTH_IN  (8),
        .WIDTH_OUT (3),
        .DELAY_RISE(5),
        .DELAY_FALL(3)
    ) dut (
        .Clk       (Clk),
        .Clear_bar (Clear_bar),
        .Enable_bar(Enable_bar),
        .D_bar     (D_bar),
        .Ack       (Ack),
        .A_bar     (A_bar),
        .GS_bar    (GS_bar),
        .EO_bar    (EO_bar)
    );

    // Clock: period 40, rising edges at 20, 60, 100, ...
    initial Clk = 1'b0;
    always #20 Clk = ~Clk;

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int i = 0; i < 8; i++) pend[i] = 1'b0;
        grant = -1;
    endfunction

    function automatic int highest_pending();
        int h;
        h = -1;
        for (int i = 0; i < 8; i++) if (pend[i]) h = i;
        return h;
    endfunction

    // One rising edge: decide on the grant from the pending lines as they
    // were before the edge, then capture the requests seen at the edge.
    function automatic void model_edge();
        int h;
        if (Enable_bar) begin
            grant = -1;
        end else if (grant >= 0) begin
            if (Ack) begin
                pend[grant] = 1'b0;
                grant = -1;
            end
        end else begin
            h = highest_pending();
            if (h >= 0) grant = h;
        end
        for (int i = 0; i < 8; i++) if (D_bar[i] == 1'b0) pend[i] = 1'b1;
    endfunction

    // ---------------- comparison helpers ----------------
    task automatic cmp_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cmp_vec(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag);
        logic       e_gs;
        logic       e_eo;
        logic [2:0] e_a;
        e_gs = !(Enable_bar == 1'b0 && grant >= 0);
        e_a  = e_gs ? 3'd7 : 3'(7 - grant);
        e_eo = !(Enable_bar == 1'b0 && grant < 0 && highest_pending() < 0);
        cmp_vec({tag, "/A_bar"}, A_bar, e_a);
        cmp_bit({tag, "/GS_bar"}, GS_bar, e_gs);
        cmp_bit({tag, "/EO_bar"}, EO_bar, e_eo);
    endtask

    // Called at a falling edge with inputs already driven: run one rising
    // edge, check 10 units after it, and return at the next falling edge.
    task automatic step(input string tag);
        @(posedge Clk);
        model_edge();
        #10;
        check_out(tag);
        @(negedge Clk);
    endtask

    // Called at a falling edge: pulse Clear_bar low well away from Clk.
    task automatic clear_pulse(input string tag);
        Clear_bar = 1'b0;
        model_reset();
        #8;
        check_out(tag);
        #2;
        Clear_bar = 1'b1;
    endtask

    task automatic ack_pair(input string tag);
        Ack = 1'b1;
        step({tag, "_ack"});
        Ack = 1'b0;
        step({tag, "_next"});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] d;
        n_cmp      = 0;
        n_fail     = 0;
        Clear_bar  = 1'b0;
        Enable_bar = 1'b0;
        D_bar      = 8'b0000_0000;
        Ack        = 1'b0;
        model_reset();

        // Held in reset across one rising edge.
        #30;
        check_out("reset_hold");
        cmp_vec("reset_A", A_bar, 3'b111);
        cmp_bit("reset_GS", GS_bar, 1'b1);
        cmp_bit("reset_EO", EO_bar, 1'b0);

        // Release; first edge captures, second edge grants line 7.
        @(negedge Clk);
        Clear_bar = 1'b1;
        step("rel_edge1");
        cmp_bit("rel_edge1_GS", GS_bar, 1'b1);
        step("rel_edge2");
        cmp_bit("rel_edge2_GS", GS_bar, 1'b0);
        cmp_vec("rel_edge2_A", A_bar, 3'b000);
        D_bar = 8'hFF;
        for (int i = 0; i < 8; i++) ack_pair("drain");
        cmp_bit("drain_EO", EO_bar, 1'b0);

        // Lines 3 and 1 pulsed for one cycle.
        D_bar = 8'b1111_0101;
        step("l31_capture");
        D_bar = 8'hFF;
        step("l31_grant3");
        cmp_vec("l31_code3", A_bar, 3'b100);
        Ack = 1'b1;
        step("l31_ack3");
        cmp_bit("l31_gap_GS", GS_bar, 1'b1);
        Ack = 1'b0;
        step("l31_grant1");
        cmp_vec("l31_code1", A_bar, 3'b110);

        // Line 6 arrives during grant of line 1: no pre-emption.
        D_bar = 8'b1011_1111;
        step("np_req6");
        cmp_vec("np_hold1_a", A_bar, 3'b110);
        D_bar = 8'hFF;
        step("np_hold");
        cmp_vec("np_hold1_b", A_bar, 3'b110);
        Ack = 1'b1;
        step("np_ack1");
        cmp_bit("np_gap_GS", GS_bar, 1'b1);
        Ack = 1'b0;
        step("np_grant6");
        cmp_vec("np_code6", A_bar, 3'b001);
        ack_pair("np_done");
        cmp_bit("np_idle_GS", GS_bar, 1'b1);
        cmp_bit("np_idle_EO", EO_bar, 1'b0);

        // Enable_bar raised during grant of line 5.
        D_bar = 8'b1101_1111;
        step("en_req5");
        D_bar = 8'hFF;
        step("en_grant5");
        cmp_vec("en_code5", A_bar, 3'b010);
        Enable_bar = 1'b1;
        #2;
        cmp_bit("en_gs_delay", GS_bar, 1'b0);
        #6;
        check_out("en_forced");
        cmp_vec("en_forced_A", A_bar, 3'b111);
        cmp_bit("en_forced_GS", GS_bar, 1'b1);
        cmp_bit("en_forced_EO", EO_bar, 1'b1);
        step("en_disabled_edge");
        Enable_bar = 1'b0;
        step("en_regrant");
        cmp_vec("en_code5_again", A_bar, 3'b010);
        ack_pair("en_done");

        // Ack while line 2 is still requesting: set wins.
        D_bar = 8'b1111_1011;
        step("sw_req2");
        step("sw_grant2");
        cmp_vec("sw_code2", A_bar, 3'b101);
        Ack = 1'b1;
        step("sw_ack");
        cmp_bit("sw_gap_GS", GS_bar, 1'b1);
        Ack   = 1'b0;
        D_bar = 8'hFF;
        step("sw_regrant");
        cmp_vec("sw_code2_again", A_bar, 3'b101);
        ack_pair("sw_done");

        // Asynchronous clear mid-grant with line 0 pending.
        D_bar = 8'b0111_1111;
        step("ac_req7");
        D_bar = 8'b1111_1110;
        step("ac_grant7");
        D_bar = 8'hFF;
        Clear_bar = 1'b0;
        model_reset();
        #8;
        check_out("ac_in_reset");
        cmp_vec("ac_A", A_bar, 3'b111);
        cmp_bit("ac_GS", GS_bar, 1'b1);
        cmp_bit("ac_EO", EO_bar, 1'b0);
        #2;
        Clear_bar = 1'b1;
        step("ac_after");
        cmp_bit("ac_after_EO", EO_bar, 1'b0);
        cmp_bit("ac_after_GS", GS_bar, 1'b1);

        // Randomized run against the model.
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < 8; b++) d[b] = ($urandom_range(0, 7) != 0);
            D_bar      = d;
            Ack        = ($urandom_range(0, 2) == 0);
            Enable_bar = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 39) == 0) clear_pulse("rnd_clear");
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
